fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined SIMD/AES processor.
- Holds the program counter and selects the next PC from sequential, writeback-redirect and branch targets.
- Presents PCF to the external instruction memory and receives the fetched word back on `instruction`.
- Registers that word into the IF/ID pipeline register for the decode stage.

---
 rtl/fetch_stage.sv | 57 +++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection and the
// IF/ID pipeline register feeding the decode stage.
module fetch_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ResultW,
  input  logic [N-1:0] ExtImmE,
  input  logic         PCSrcW,
  input  logic         BranchTakenE,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic [N-1:0] instruction,
  output logic [N-1:0] PCF,
  output logic [N-1:0] InstrD,
  output logic [N-1:0] PCPlus8D
);

  logic [N-1:0] PCPlus4F;
  logic [N-1:0] PCNextF;

  // Sequential fetch address; wraps modulo 2^N.
  assign PCPlus4F = PCF + N'(4);

  // PCF is one word ahead of the decode instruction, so PCF+4 is its PC+8.
  assign PCPlus8D = PCPlus4F;

  // Next-PC select: execute branch beats writeback redirect beats PC+4.
  always_comb begin
    PCNextF = PCPlus4F;
    if (BranchTakenE)
      PCNextF = ExtImmE;
    else if (PCSrcW)
      PCNextF = ResultW;
  end

  // Program counter; StallF acts as the load enable.
  always_ff @(posedge clk) begin
    if (rst)
      PCF <= '0;
    else if (StallF)
      PCF <= PCNextF;
  end

  // IF/ID register; flush inserts a zero bubble even when not enabled.
  always_ff @(posedge clk) begin
    if (rst)
      InstrD <= '0;
    else if (FlushD)
      InstrD <= '0;
    else if (StallD)
      InstrD <= instruction;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus randomized control traffic against a behavioural model.
module tb_fetch_stage;

  localparam int N = 32;
  localparam int MEMWORDS = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ResultW, ExtImmE;
  logic         PCSrcW, BranchTakenE, StallF, StallD, FlushD;
  logic [N-1:0] instruction;
  logic [N-1:0] PCF, InstrD, PCPlus8D;

  logic [N-1:0] mem [MEMWORDS];

  int tests = 0;
  int fails = 0;

  // behavioural model state
  logic [N-1:0] expPc, expInstr;
  bit           modelValid = 1'b0;

  fetch_stage #(.N(N)) dut (
    .clk(clk), .rst(rst), .ResultW(ResultW), .ExtImmE(ExtImmE),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .instruction(instruction),
    .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] memRead(input logic [N-1:0] addr);
    logic [N-3:0] idx;
    idx = addr[N-1:2];
    if (idx < MEMWORDS) return mem[idx[5:0]];
    return '0;
  endfunction

  // instruction memory environment: combinational read of PCF
  assign instruction = memRead(PCF);

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model update from sampled inputs, then per-cycle compare
  always @(posedge clk) begin
    logic [N-1:0] nPc, nIns;
    if (rst) begin
      nPc = '0;
      nIns = '0;
      modelValid = 1'b1;
    end else begin
      if (FlushD)      nIns = '0;
      else if (StallD) nIns = memRead(expPc);
      else             nIns = expInstr;
      if (!StallF)           nPc = expPc;
      else if (BranchTakenE) nPc = ExtImmE;
      else if (PCSrcW)       nPc = ResultW;
      else                   nPc = expPc + 32'd4;
    end
    expPc = nPc;
    expInstr = nIns;
    #1;
    if (modelValid) begin
      check("model_PCF", PCF, expPc);
      check("model_InstrD", InstrD, expInstr);
      check("model_PCPlus8D", PCPlus8D, expPc + 32'd4);
    end
  end

  task automatic setIn(input bit r, input bit sf, input bit sd, input bit fl,
                       input bit br, input logic [N-1:0] ext,
                       input bit ps, input logic [N-1:0] res);
    rst = r; StallF = sf; StallD = sd; FlushD = fl;
    BranchTakenE = br; ExtImmE = ext; PCSrcW = ps; ResultW = res;
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < MEMWORDS; i++) mem[i] = $urandom;

    // reset
    setIn(1, 1, 1, 0, 0, '0, 0, '0);
    cycle();
    check("rst_PCF", PCF, 32'h0);
    check("rst_InstrD", InstrD, 32'h0);
    check("rst_PCPlus8D", PCPlus8D, 32'h4);

    // sequential fetch
    setIn(0, 1, 1, 0, 0, '0, 0, '0);
    cycle();
    check("seq_PCF1", PCF, 32'h4);
    check("seq_InstrD1", InstrD, mem[0]);
    cycle();
    cycle();
    check("seq_PCF3", PCF, 32'hC);
    check("seq_InstrD3", InstrD, mem[2]);
    check("seq_PCPlus8D", PCPlus8D, 32'h10);

    // branch then sequential
    setIn(0, 1, 1, 0, 1, 32'h40, 0, '0);
    cycle();
    check("br_PCF", PCF, 32'h40);
    setIn(0, 1, 1, 0, 0, '0, 0, '0);
    cycle();
    check("br_next_PCF", PCF, 32'h44);

    // branch beats writeback redirect
    setIn(0, 1, 1, 0, 1, 32'h40, 1, 32'h80);
    cycle();
    check("prio_PCF", PCF, 32'h40);

    // writeback redirect
    setIn(0, 1, 1, 0, 0, '0, 1, 32'h20);
    cycle();
    check("wb_PCF", PCF, 32'h20);
    check("wb_InstrD", InstrD, mem[16]);

    // stall both registers for two cycles
    setIn(0, 0, 0, 0, 0, '0, 0, '0);
    cycle();
    cycle();
    check("stall_PCF", PCF, 32'h20);
    check("stall_InstrD", InstrD, mem[16]);

    // flush while decode is stalled
    setIn(0, 0, 0, 1, 0, '0, 0, '0);
    cycle();
    check("flush_InstrD", InstrD, 32'h0);
    check("flush_PCF", PCF, 32'h20);

    // wraparound via writeback redirect
    setIn(0, 1, 1, 0, 0, '0, 1, 32'hFFFF_FFFC);
    cycle();
    check("wrap_PCF", PCF, 32'hFFFF_FFFC);
    check("wrap_PCPlus8D", PCPlus8D, 32'h0);
    setIn(0, 1, 1, 0, 0, '0, 0, '0);
    cycle();
    check("wrap_next_PCF", PCF, 32'h0);
    check("oob_InstrD", InstrD, 32'h0);

    // mid-run reset at PCF=0x10
    repeat (4) cycle();
    check("pre_rst_PCF", PCF, 32'h10);
    setIn(1, 1, 1, 0, 0, '0, 0, '0);
    cycle();
    check("midrst_PCF", PCF, 32'h0);
    check("midrst_InstrD", InstrD, 32'h0);

    // randomized control traffic
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] e, r;
      e = ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 6'($urandom), 2'b00};
      r = ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 6'($urandom), 2'b00};
      setIn($urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, e,
            $urandom_range(0, 5) == 0, r);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
